stdout_uart_tx: RTL and testbench
=================================

# stdout_uart_tx

Downstream consumer of the core's stdout channel. Accepts one 16-bit word per valid/ready handshake and renders it as four uppercase ASCII hex digits plus a line feed. The five characters go out on an 8N1 UART transmit line. The block is the physical sink for every store to the memory-mapped stdout address, and it back-pressures the core until the whole line has been shifted out.

## Interface
Parameters:
- CLK_DIV, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_ni  input  1  reset. Asynchronous, active-low; one clock only.
- val_i  input  1  stdout word valid from the core.
- data_i  input  16  stdout word; sampled only on the accept edge.
- rdy_o  output  1  ready to accept a word. High only in IDLE.
- tx_o  output  1  UART serial output. Idle/mark level is 1.
- busy_o  output  1  high while a line is being transmitted (inverse of rdy_o).

## Operation
- Accept: handshake completes on a rising edge with val_i & rdy_o. data_i is latched into a 16-bit holding register; FSM moves IDLE→SEND.
- Character sequence (char index 0..4):
  - idx 0: nibble [15:12]
  - idx 1: nibble [11:8]
  - idx 2: nibble [7:4]
  - idx 3: nibble [3:0]
  - idx 4: 0x0A
- Hex encoding: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- Frame per character: 10 bits.
  - Start bit: 0.
  - Data bits d0..d7: LSB first.
  - Stop bit: 1.
  - No parity.
- Counters:
  - baud counter: 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - bit index: 0..9.
  - char index: 0..4.
- Advance rules:
  - Bit index advances when the baud counter wraps.
  - Char index advances when bit index 9 completes.
  - SEND→IDLE when char 4's stop bit completes.
- FSM has two states:
  - IDLE: tx_o=1, rdy_o=1, busy_o=0.
  - SEND: tx_o = current frame bit, rdy_o=0, busy_o=1.
- While busy, val_i and data_i are ignored. A word changing under val_i is neither latched nor lost; the core simply stalls.
- tx_o is driven from a flop, never combinationally from counters.

## Timing
- Reset values:
  - tx_o=1, rdy_o=1, busy_o=0.
  - FSM IDLE; all counters 0; holding register 0.
- val_i is not accepted while rst_ni is low.
- Accept on edge k: tx_o goes to 0 (start bit of char 0) after edge k. It holds each bit for exactly CLK_DIV cycles.
- Line length: exactly 50·CLK_DIV cycles from the accept edge to the edge where rdy_o returns high.
- rdy_o is high for at least one full cycle between lines. A word accepted in that cycle starts its start bit on the next cycle, so there is no extra idle bit time.
- Reset asserted mid-line:
  - tx_o returns to 1 asynchronously; the partial character is truncated.
  - The latched word is discarded; FSM goes to IDLE.
  - rdy_o is high once rst_ni is released; no retransmission.
- Simultaneous val_i on the completion edge of the last stop bit: not accepted, because rdy_o is still 0 on that edge. It is accepted on the following edge.
- CLK_DIV=2 edge case: the baud counter wraps every other cycle, and the frame must still be exactly 20 cycles per character.

## Test plan
- CLK_DIV=4; after reset, send 0x1A2F.
  - Decoded bytes on tx_o: 0x31, 0x41, 0x32, 0x46, 0x0A.
  - rdy_o low for exactly 200 cycles.
- CLK_DIV=4; send 0x0000, then 0xFFFF with val_i held continuously.
  - Second word accepted on the first cycle rdy_o=1.
  - Bytes: 0x30×4, 0x0A, then 0x46×4, 0x0A.
  - No idle gap beyond that one ready cycle.
- CLK_DIV=4; word 0x9B0C accepted; while busy, data_i toggles and val_i pulses.
  - Output is still 0x39, 0x42, 0x30, 0x43, 0x0A.
  - Exactly one handshake is counted.
- CLK_DIV=4; accept 0x1234, assert rst_ni low during the 3rd character's data bits.
  - tx_o=1 immediately; rdy_o=1 after release.
  - Next word 0x5678 transmits cleanly as 0x35, 0x36, 0x37, 0x38, 0x0A.
- CLK_DIV=2 and CLK_DIV=5; word 0xC3E7.
  - Bit periods measured at exactly 2 and 5 cycles.
  - Bytes 0x43, 0x33, 0x45, 0x37, 0x0A.
  - Line durations 100 and 250 cycles.

Source files
------------

// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: renders each accepted 16-bit word as four hex digits plus LF on an 8N1 UART line
module stdout_uart_tx #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        val_i,
  input  logic [15:0] data_i,
  output logic        rdy_o,
  output logic        tx_o,
  output logic        busy_o
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [15:0] word, word_n;
  logic [CW-1:0] baud, baud_n;
  logic [3:0] bit_idx, bit_n;
  logic [2:0] char_idx, char_n;
  logic tx, tx_n;
  logic [3:0] nib;
  logic [7:0] chr;
  logic wrap;
  // current character byte and baud wrap strobe
  always_comb begin
    nib = char_idx == 3'd0 ? word[15:12] : char_idx == 3'd1 ? word[11:8] :
          char_idx == 3'd2 ? word[7:4] : word[3:0];
    chr = char_idx == 3'd4 ? 8'h0A : nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    wrap = baud == CW'(CLK_DIV - 1);
  end
  // next state; tx_n is the level of the bit that begins on the next edge
  always_comb begin
    state_n = state;
    word_n = word;
    baud_n = baud;
    bit_n = bit_idx;
    char_n = char_idx;
    tx_n = tx;
    if (state == IDLE) begin
      if (val_i) begin
        state_n = SEND;
        word_n = data_i;
        baud_n = '0;
        bit_n = 4'd0;
        char_n = 3'd0;
        tx_n = 1'b0;
      end
    end else begin
      baud_n = wrap ? '0 : baud + 1'b1;
      if (wrap) begin
        if (bit_idx == 4'd9) begin
          bit_n = 4'd0;
          char_n = char_idx == 3'd4 ? 3'd0 : char_idx + 3'd1;
          state_n = char_idx == 3'd4 ? IDLE : SEND;
          tx_n = char_idx == 3'd4;
        end else begin
          bit_n = bit_idx + 4'd1;
          tx_n = bit_idx == 4'd8 ? 1'b1 : chr[bit_idx[2:0]];
        end
      end
    end
  end
  // state and output registers; reset truncates any line in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      word <= '0;
      baud <= '0;
      bit_idx <= 4'd0;
      char_idx <= 3'd0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      word <= word_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      char_idx <= char_n;
      tx <= tx_n;
    end
  end
  assign rdy_o = state == IDLE;
  assign busy_o = state == SEND;
  assign tx_o = tx;
endmodule

// File: tb/tb_stdout_uart_tx.sv
// tb_stdout_uart_tx: scoreboard bench decoding the UART line of three differently divided instances
module tb_stdout_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic val[3];
  logic [15:0] data[3];
  logic rdy[3], tx[3], busy[3];
  int checks = 0, failures = 0, rst_cnt = 0, hs = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(negedge rst_n) rst_cnt++;
  always @(posedge clk) if (rst_n && val[0] && rdy[0]) hs++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push5(input logic [7:0] a, b, c, d, e);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    exp_q.push_back(d); exp_q.push_back(e);
  endtask

  task automatic accept(input int s, input logic [15:0] w);
    int n = 0;
    val[s] = 1'b1;
    data[s] = w;
    while (!rdy[s] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_line(input int s, input int start, output int low);
    low = start;
    while (!rdy[s] && low < 5000) begin
      low++;
      @(negedge clk);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int DV = g == 0 ? 4 : g == 1 ? 2 : 5;
    stdout_uart_tx #(.CLK_DIV(DV)) dut (
      .clk_i(clk), .rst_ni(rst_n), .val_i(val[g]), .data_i(data[g]),
      .rdy_o(rdy[g]), .tx_o(tx[g]), .busy_o(busy[g])
    );
    initial begin : mon
      logic [7:0] b;
      logic stp;
      int rc;
      forever begin
        @(negedge clk);
        if (rst_n && tx[g] === 1'b0) begin
          rc = rst_cnt;
          b = '0;
          stp = 1'b0;
          for (int k = 0; k < 9; k++) begin
            repeat (DV) @(negedge clk);
            if (k < 8) b[k] = tx[g];
            else stp = tx[g];
          end
          if (rc == rst_cnt) begin
            chk($sformatf("stop_bit_u%0d", g), 32'(stp), 32'd1);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_byte_u%0d: got %0h expected none", g, b);
            end else chk($sformatf("byte_u%0d", g), 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int low, n, h0, dv;
    for (int i = 0; i < 3; i++) begin
      val[i] = 1'b0;
      data[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", 32'(tx[i]), 32'd1);
      chk("reset_rdy", 32'(rdy[i]), 32'd1);
      chk("reset_busy", 32'(busy[i]), 32'd0);
    end
    push5(8'h31, 8'h41, 8'h32, 8'h46, 8'h0A);
    accept(0, 16'h1A2F);
    val[0] = 1'b0;
    chk("t1_busy", 32'(busy[0]), 32'd1);
    wait_line(0, 0, low);
    chk("t1_rdy_low", 32'(low), 32'd200);
    h0 = hs;
    push5(8'h30, 8'h30, 8'h30, 8'h30, 8'h0A);
    push5(8'h46, 8'h46, 8'h46, 8'h46, 8'h0A);
    accept(0, 16'h0000);
    data[0] = 16'hFFFF;
    wait_line(0, 0, low);
    chk("t2_rdy_low_a", 32'(low), 32'd200);
    @(negedge clk);
    chk("t2_accept_first_ready", 32'(rdy[0]), 32'd0);
    chk("t2_start_immediate", 32'(tx[0]), 32'd0);
    val[0] = 1'b0;
    wait_line(0, 0, low);
    chk("t2_rdy_low_b", 32'(low), 32'd200);
    chk("t2_handshakes", 32'(hs - h0), 32'd2);
    h0 = hs;
    push5(8'h39, 8'h42, 8'h30, 8'h43, 8'h0A);
    accept(0, 16'h9B0C);
    for (int i = 0; i < 150; i++) begin
      val[0] = i % 4 == 1;
      data[0] = 16'(i * 16'h1357);
      @(negedge clk);
    end
    val[0] = 1'b0;
    wait_line(0, 0, low);
    chk("t3_rdy_low", 32'(low + 150), 32'd200);
    chk("t3_handshakes", 32'(hs - h0), 32'd1);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    accept(0, 16'h1234);
    val[0] = 1'b0;
    repeat (91) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("t4_tx_on_reset", 32'(tx[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_rdy_after_reset", 32'(rdy[0]), 32'd1);
    chk("t4_busy_after_reset", 32'(busy[0]), 32'd0);
    chk("t4_queue_after_reset", 32'(exp_q.size()), 32'd0);
    repeat (60) @(negedge clk);
    push5(8'h35, 8'h36, 8'h37, 8'h38, 8'h0A);
    accept(0, 16'h5678);
    val[0] = 1'b0;
    wait_line(0, 0, low);
    chk("t4_rdy_low", 32'(low), 32'd200);
    for (int s = 1; s < 3; s++) begin
      dv = s == 1 ? 2 : 5;
      push5(8'h43, 8'h33, 8'h45, 8'h37, 8'h0A);
      accept(s, 16'hC3E7);
      val[s] = 1'b0;
      n = 0;
      while (tx[s] == 1'b0 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("t5_bit_period_div%0d", dv), 32'(n), 32'(dv));
      wait_line(s, n, low);
      chk($sformatf("t5_line_div%0d", dv), 32'(low), 32'(50 * dv));
    end
    repeat (20) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
